// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Synchronises and debounces a bus of raw push-button inputs. For each key
//   it produces a clean pressed level plus single-cycle press, release and
//   long-press pulses. It also reports one summarised event per cycle for the
//   mode-control logic.
//
// Ports
//   CLOCK_50     in   1         system clock
//   reset        in   1         synchronous, active-high reset
//   keys         in   NUM_KEYS  raw asynchronous button inputs
//   key_level    out  NUM_KEYS  debounced state, 1 = pressed
//   key_press    out  NUM_KEYS  1-cycle pulse on accepted press
//   key_release  out  NUM_KEYS  1-cycle pulse on accepted release
//   key_long     out  NUM_KEYS  1-cycle pulse when a hold reaches LONG_CYCLES
//   event_valid  out  1         1-cycle pulse: some key event this cycle
//   event_key    out  3         index of the reported key (lowest index wins)
//   event_type   out  2         01 press, 10 release, 11 long
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int NUM_KEYS        = 7,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                event_valid,
    output logic [2:0]          event_key,
    output logic [1:0]          event_type
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DB_DN = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_DB_UP = 2'd3;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    // Polarity is normalised before the synchroniser. XOR with a constant
    // adds no glitch risk. It also means a cleared synchroniser reads as
    // "not pressed", so leaving reset never looks like a press.
    localparam logic [NUM_KEYS-1:0] POL_MASK = {NUM_KEYS{KEY_ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    logic [1:0]    state_q    [NUM_KEYS];
    logic [1:0]    state_d    [NUM_KEYS];
    logic [CW-1:0] cnt_q      [NUM_KEYS];
    logic [CW-1:0] cnt_d      [NUM_KEYS];
    logic [LW-1:0] long_cnt_q [NUM_KEYS];
    logic [LW-1:0] long_cnt_d [NUM_KEYS];

    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic                ev_valid_q, ev_valid_d;
    logic [2:0]          ev_key_q, ev_key_d;
    logic [1:0]          ev_type_q, ev_type_d;

    assign pressed = sync2_q;

    // Next-state logic for every key FSM, plus selection of the summary event.
    // Pulses are computed alongside the transition that causes them. The event
    // fields are registered in the same edge as the per-key pulse vectors.
    always_comb begin
        level_d    = level_q;
        press_d    = '0;
        rel_d      = '0;
        long_d     = '0;
        ev_valid_d = 1'b0;
        ev_key_d   = ev_key_q;
        ev_type_d  = ev_type_q;

        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k]    = state_q[k];
            cnt_d[k]      = cnt_q[k];
            long_cnt_d[k] = long_cnt_q[k];

            // The hold timer runs through release bounces. It saturates, so the
            // long pulse fires at most once per hold.
            if (state_q[k] == ST_HELD || state_q[k] == ST_DB_UP) begin
                if (long_cnt_q[k] != LONG_LAST) begin
                    long_cnt_d[k] = long_cnt_q[k] + 1'b1;
                end
                if (long_cnt_q[k] == LONG_PRE) begin
                    long_d[k] = 1'b1;
                end
            end

            case (state_q[k])
                ST_IDLE: begin
                    if (pressed[k]) begin
                        state_d[k] = ST_DB_DN;
                        cnt_d[k]   = CW'(1);
                    end
                end
                ST_DB_DN: begin
                    if (!pressed[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k]    = ST_HELD;
                        cnt_d[k]      = '0;
                        level_d[k]    = 1'b1;
                        press_d[k]    = 1'b1;
                        long_cnt_d[k] = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!pressed[k]) begin
                        state_d[k] = ST_DB_UP;
                        cnt_d[k]   = CW'(1);
                    end
                end
                ST_DB_UP: begin
                    if (pressed[k]) begin
                        state_d[k] = ST_HELD;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k]    = ST_IDLE;
                        cnt_d[k]      = '0;
                        level_d[k]    = 1'b0;
                        rel_d[k]      = 1'b1;
                        long_cnt_d[k] = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
        end

        // Scan from the top down so that the lowest-index key is reported.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (press_d[k] || rel_d[k] || long_d[k]) begin
                ev_valid_d = 1'b1;
                ev_key_d   = 3'(k);
                if (long_d[k]) begin
                    ev_type_d = EV_LONG;
                end else if (rel_d[k]) begin
                    ev_type_d = EV_RELEASE;
                end else begin
                    ev_type_d = EV_PRESS;
                end
            end
        end
    end

    // All state registers, with synchronous reset. Reset drops every key back
    // to IDLE without emitting a release. A key that is still held is then
    // accepted again as a fresh press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            long_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_type_q  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k]    <= ST_IDLE;
                cnt_q[k]      <= '0;
                long_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q    <= keys ^ POL_MASK;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_type_q  <= ev_type_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k]    <= state_d[k];
                cnt_q[k]      <= cnt_d[k];
                long_cnt_q[k] <= long_cnt_d[k];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign key_long    = long_q;
    assign event_valid = ev_valid_q;
    assign event_key   = ev_key_q;
    assign event_type  = ev_type_q;

endmodule
